// File: rtl/operand_display_scanner_if.sv
// ----------------------------------------------------------------------------
// operand_display_scanner_if
// Bundles the operand load handshake and the display outputs of
// operand_display_scanner.
//   load       : one-cycle request to latch a_in/b_in for display
//   a_in, b_in : operands A and B
//   pending    : a loaded value waits for the next frame boundary
//   load_ack   : one-cycle pulse when new operands become active
//   frame_done : one-cycle pulse at the end of each 4-digit frame
//   seg[0:6]   : active-low segments a..g
//   digit_en   : active-low digit enables, bit i selects digit i
// master = operand-capture side, slave = the scanner.
// ----------------------------------------------------------------------------
interface operand_display_scanner_if;
    logic       load;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       pending;
    logic       load_ack;
    logic       frame_done;
    logic [0:6] seg;
    logic [3:0] digit_en;

    modport master (
        output load, a_in, b_in,
        input  pending, load_ack, frame_done, seg, digit_en
    );

    modport slave (
        input  load, a_in, b_in,
        output pending, load_ack, frame_done, seg, digit_en
    );
endinterface

// File: rtl/operand_display_scanner.sv
// ----------------------------------------------------------------------------
// operand_display_scanner
// Time-multiplexes operands A and B onto a 4-digit common-anode 7-segment
// display (d0=A[3:0], d1=A[7:4], d2=B[3:0], d3=B[7:4]). New operands are
// held in a shadow register and only become visible at a frame boundary, so
// one frame never mixes old and new data.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : operand_display_scanner_if.slave (handshake + display outputs)
// Parameters:
//   PRESCALE     : clock cycles per digit slot (>= 2)
//   BLANK_CYCLES : cycles at slot start with all digits off (< PRESCALE)
//   BLANK_LZ     : 1 = blank a zero high nibble of an operand
// All outputs are registered and reflect the pre-edge slot position.
// ----------------------------------------------------------------------------
module operand_display_scanner #(
    parameter int unsigned PRESCALE     = 1000,
    parameter int unsigned BLANK_CYCLES = 1,
    parameter int unsigned BLANK_LZ     = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    operand_display_scanner_if.slave      bus
);

    localparam int unsigned     PW      = $clog2(PRESCALE);
    localparam logic [PW-1:0]   P_LAST  = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]   P_BLANK = PW'(BLANK_CYCLES);

    logic [PW-1:0] p_q, p_d;
    logic [1:0]    d_q, d_d;
    logic [15:0]   shadow_q, shadow_d;   // {A, B}
    logic [15:0]   active_q, active_d;   // {A, B}
    logic          pending_q, pending_d;
    logic          load_ack_q, load_ack_d;
    logic          frame_done_q, frame_done_d;
    logic [0:6]    seg_q, seg_d;
    logic [3:0]    digit_en_q, digit_en_d;

    logic          frame_edge;
    logic [3:0]    nibble;

    function automatic logic [0:6] hex7(input logic [3:0] v);
        logic [0:6] s;
        case (v)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    always_comb begin
        p_d          = p_q + PW'(1);
        d_d          = d_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        pending_d    = pending_q;
        load_ack_d   = 1'b0;
        frame_edge   = (p_q == P_LAST) && (d_q == 2'd3);
        frame_done_d = frame_edge;

        if (p_q == P_LAST) begin
            p_d = '0;
            d_d = d_q + 2'd1;
        end

        if (bus.load) begin
            shadow_d  = {bus.a_in, bus.b_in};
            pending_d = 1'b1;
        end

        // A load on the boundary edge bypasses the shadow so it is not
        // deferred by a whole frame.
        if (frame_edge) begin
            if (bus.load) begin
                active_d   = {bus.a_in, bus.b_in};
                pending_d  = 1'b0;
                load_ack_d = 1'b1;
            end else if (pending_q) begin
                active_d   = shadow_q;
                pending_d  = 1'b0;
                load_ack_d = 1'b1;
            end
        end

        case (d_q)
            2'd0:    nibble = active_q[11:8];
            2'd1:    nibble = active_q[15:12];
            2'd2:    nibble = active_q[3:0];
            default: nibble = active_q[7:4];
        endcase

        digit_en_d = (p_q < P_BLANK) ? 4'hF : ~(4'b0001 << d_q);
        seg_d      = hex7(nibble);
        // Odd digits carry the high nibble; only the segments blank, the
        // enable still follows the scan.
        if ((BLANK_LZ != 0) && d_q[0] && (nibble == 4'h0)) begin
            seg_d = '1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            p_q          <= '0;
            d_q          <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            pending_q    <= 1'b0;
            load_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= '1;
            digit_en_q   <= '1;
        end else begin
            p_q          <= p_d;
            d_q          <= d_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            load_ack_q   <= load_ack_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            digit_en_q   <= digit_en_d;
        end
    end

    assign bus.pending    = pending_q;
    assign bus.load_ack   = load_ack_q;
    assign bus.frame_done = frame_done_q;
    assign bus.seg        = seg_q;
    assign bus.digit_en   = digit_en_q;

endmodule

// File: tb/tb_operand_display_scanner.sv
// ----------------------------------------------------------------------------
// tb_operand_display_scanner
// Directed bench for operand_display_scanner with PRESCALE=4, BLANK_CYCLES=1.
// u_dut uses BLANK_LZ=0, u_lz uses BLANK_LZ=1; both share clock and reset.
// ecnt counts rising edges since the last reset release; the output observed
// after edge e reflects pre-edge p=(e-1)%4, d=((e-1)/4)%4, and frame
// boundaries fall on edges 16, 32, 48, ...
// ----------------------------------------------------------------------------
module tb_operand_display_scanner;

    logic clock;
    logic reset;
    int   ecnt;
    int   n_cmp;
    int   n_bad;

    operand_display_scanner_if bus0 ();
    operand_display_scanner_if bus1 ();

    operand_display_scanner #(
        .PRESCALE     (4),
        .BLANK_CYCLES (1),
        .BLANK_LZ     (0)
    ) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    operand_display_scanner #(
        .PRESCALE     (4),
        .BLANK_CYCLES (1),
        .BLANK_LZ     (1)
    ) u_lz (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
        ecnt++;
    endtask

    task automatic run_to(input int e);
        while (ecnt < e) tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_disp(input string tag, input logic [3:0] en, input logic [6:0] sg);
        chk({tag, ".en"},  {4'h0, bus0.digit_en}, {4'h0, en});
        chk({tag, ".seg"}, {1'b0, bus0.seg},      {1'b0, sg});
    endtask

    task automatic chk_lz(input string tag, input logic [3:0] en, input logic [6:0] sg);
        chk({tag, ".lz_en"},  {4'h0, bus1.digit_en}, {4'h0, en});
        chk({tag, ".lz_seg"}, {1'b0, bus1.seg},      {1'b0, sg});
    endtask

    // {pending, load_ack, frame_done}
    task automatic chk_flags(input string tag, input logic pd, input logic ak, input logic fd);
        chk({tag, ".flags"},
            {5'h0, bus0.pending, bus0.load_ack, bus0.frame_done},
            {5'h0, pd, ak, fd});
    endtask

    task automatic load0(input logic [7:0] a, input logic [7:0] b);
        bus0.load = 1'b1;
        bus0.a_in = a;
        bus0.b_in = b;
        tick();
        bus0.load = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        ecnt  = 0;
        reset = 1'b0;
        bus0.load = 1'b0; bus0.a_in = '0; bus0.b_in = '0;
        bus1.load = 1'b0; bus1.a_in = '0; bus1.b_in = '0;

        // Reset values
        #12;
        chk_disp("rst", 4'b1111, 7'b1111111);
        chk_flags("rst", 1'b0, 1'b0, 1'b0);
        chk_lz("rst", 4'b1111, 7'b1111111);
        @(posedge clock);
        #1;
        reset = 1'b1;
        ecnt  = 0;

        // Idle scan
        run_to(1);  chk_disp("e1", 4'b1111, 7'b0000001); chk_flags("e1", 1'b0, 1'b0, 1'b0);
        run_to(2);  chk_disp("e2", 4'b1110, 7'b0000001);
        run_to(4);  chk_disp("e4", 4'b1110, 7'b0000001);
        run_to(5);  chk_disp("e5_blank", 4'b1111, 7'b0000001);
        run_to(6);  chk_disp("e6", 4'b1101, 7'b0000001);

        // u_lz gets A=07, B=00 (pending until edge 16)
        run_to(7);
        bus1.load = 1'b1; bus1.a_in = 8'h07; bus1.b_in = 8'h00;
        tick();
        bus1.load = 1'b0;
        chk("lz_pending", {7'h0, bus1.pending}, 8'h01);

        run_to(10); chk_disp("e10", 4'b1011, 7'b0000001);
        run_to(14); chk_disp("e14", 4'b0111, 7'b0000001); chk_flags("e14", 1'b0, 1'b0, 1'b0);
        run_to(15); chk_flags("e15", 1'b0, 1'b0, 1'b0);
        run_to(16); chk_flags("e16_frame", 1'b0, 1'b0, 1'b1);
        chk("lz_ack", {6'h0, bus1.load_ack, bus1.pending}, 8'h02);
        run_to(17); chk_flags("e17", 1'b0, 1'b0, 1'b0);

        // Leading-zero blanking on u_lz, plus load mid-frame on u_dut at d=1
        run_to(18); chk_disp("e18", 4'b1110, 7'b0000001); chk_lz("e18", 4'b1110, 7'b0001111);
        run_to(21);
        load0(8'h3F, 8'hA5);        // edge 22
        chk_flags("e22_load", 1'b1, 1'b0, 1'b0);
        chk_disp("e22_old", 4'b1101, 7'b0000001);
        chk_lz("e22", 4'b1101, 7'b1111111);
        run_to(26); chk_lz("e26", 4'b1011, 7'b0000001);
        run_to(30); chk_disp("e30_old", 4'b0111, 7'b0000001); chk_lz("e30", 4'b0111, 7'b1111111);
        run_to(31); chk_flags("e31", 1'b1, 1'b0, 1'b0);
        run_to(32); chk_flags("e32_ack", 1'b0, 1'b1, 1'b1);
        run_to(33); chk_flags("e33", 1'b0, 1'b0, 1'b0); chk_disp("e33", 4'b1111, 7'b0111000);
        run_to(34); chk_disp("e34_F", 4'b1110, 7'b0111000);

        // Back-to-back loads within frame 2
        run_to(35);
        load0(8'h11, 8'h22);        // edge 36
        chk_flags("e36", 1'b1, 1'b0, 1'b0);
        run_to(38); chk_disp("e38_3", 4'b1101, 7'b0000110);
        run_to(39);
        load0(8'h44, 8'h88);        // edge 40
        chk_flags("e40", 1'b1, 1'b0, 1'b0);
        run_to(42); chk_disp("e42_5", 4'b1011, 7'b0100100);
        run_to(46); chk_disp("e46_A", 4'b0111, 7'b0001000);
        run_to(47); chk_flags("e47", 1'b1, 1'b0, 1'b0);
        run_to(48); chk_flags("e48_ack", 1'b0, 1'b1, 1'b1);
        run_to(49); chk_flags("e49", 1'b0, 1'b0, 1'b0);
        run_to(50); chk_disp("e50_4", 4'b1110, 7'b1001100);
        run_to(54); chk_disp("e54_4", 4'b1101, 7'b1001100);
        run_to(58); chk_disp("e58_8", 4'b1011, 7'b0000000);
        run_to(62); chk_disp("e62_8", 4'b0111, 7'b0000000);

        // Boundary with nothing pending
        run_to(64); chk_flags("e64_noack", 1'b0, 1'b0, 1'b1);
        run_to(66); chk_disp("e66_keep", 4'b1110, 7'b1001100);

        // Load coincident with the boundary
        run_to(79);
        load0(8'hC0, 8'h0D);        // edge 80
        chk_flags("e80_same", 1'b0, 1'b1, 1'b1);
        run_to(81); chk_flags("e81", 1'b0, 1'b0, 1'b0);
        run_to(82); chk_disp("e82_0", 4'b1110, 7'b0000001);
        run_to(86); chk_disp("e86_C", 4'b1101, 7'b0110001);
        run_to(90); chk_disp("e90_d", 4'b1011, 7'b1000010);
        run_to(94); chk_disp("e94_0", 4'b0111, 7'b0000001);

        // Reset while a load is pending
        run_to(97);
        load0(8'hFF, 8'hFF);        // edge 98
        chk_flags("e98", 1'b1, 1'b0, 1'b0);
        run_to(99);
        #2;
        reset = 1'b0;
        #1;
        chk_disp("mid_rst", 4'b1111, 7'b1111111);
        chk_flags("mid_rst", 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        ecnt  = 0;

        run_to(1);  chk_flags("r1", 1'b0, 1'b0, 1'b0); chk_disp("r1", 4'b1111, 7'b0000001);
        run_to(16); chk_flags("r16_noack", 1'b0, 1'b0, 1'b1);
        run_to(17); chk_flags("r17", 1'b0, 1'b0, 1'b0);
        run_to(18); chk_disp("r18", 4'b1110, 7'b0000001);
        run_to(22); chk_disp("r22", 4'b1101, 7'b0000001);
        run_to(26); chk_disp("r26", 4'b1011, 7'b0000001);
        run_to(30); chk_disp("r30", 4'b0111, 7'b0000001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
